transport_send: RTL and testbench

//  Transmit side of the transport layer. Accepts 16-bit control words and audio samples from
//  the session layer, frames them into fixed PACKET_SIZE-byte packets (header byte + payload
//  + trailer) and writes them byte-serially into the outgoing network FIFO. Its byte stream
//  is the exact format the transport receiver parses on the far end.

---
 rtl/transport_pkg.sv | 20 ++
 rtl/tx_sample_buffer.sv | 58 +++++
 rtl/transport_send.sv | 150 +++++++++++++++
 tb/tb_transport_send.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/transport_pkg.sv
// Shared transport-layer constants and the packet FSM state type, used by both the
// sender and the far-end receiver so the byte format stays in one place.
package transport_pkg;

    localparam logic [7:0] HDR_CONTROL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO    = 8'h80;

    localparam logic [1:0] KIND_NONE    = 2'b00;
    localparam logic [1:0] KIND_CONTROL = 2'b01;
    localparam logic [1:0] KIND_AUDIO   = 2'b10;
    localparam logic [1:0] KIND_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_BODY  = 2'd2,
        S_TRAIL = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_sample_buffer.sv
// Audio sample store for one packet: fills in arrival order, then is read back one
// packet byte at a time (byte 1 = MSB of sample 0, byte 2 = its LSB, and so on).
module tx_sample_buffer
    import transport_pkg::*;
#(
    parameter int SAMPLES = 7,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_wr,
    input  logic [15:0]      i_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic [7:0]       o_rd_byte
);

    logic [15:0]      r_mem [SAMPLES];
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] w_sel;
    logic [7:0]       w_rd_byte;

    assign o_full  = (r_count == CNT_W'(SAMPLES));
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_wr && !o_full) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SAMPLES; i++) begin
            if (i_wr && !o_full && r_count == CNT_W'(i)) begin
                r_mem[i] <= i_data;
            end
        end
    end

    // Byte 0 is the header and bytes past the last sample read as zero.
    always_comb begin
        w_rd_byte = 8'h00;
        w_sel     = (i_rd_idx - IDX_W'(1)) >> 1;
        for (int i = 0; i < SAMPLES; i++) begin
            if (i_rd_idx != '0 && w_sel == IDX_W'(i)) begin
                w_rd_byte = i_rd_idx[0] ? r_mem[i][15:8] : r_mem[i][7:0];
            end
        end
    end

    assign o_rd_byte = w_rd_byte;

endmodule

// File: rtl/transport_send.sv
// Transport transmitter: frames session control words and audio samples into fixed-size
// packets written byte-serially to the network FIFO. TX_CHECKSUM_EN selects an XOR trailer.
module transport_send
    import transport_pkg::*;
#(
    parameter int PACKET_SIZE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  session_send,
    input  logic [15:0] session_data,
    output logic        session_busy,
    input  logic        net_full,
    output logic        net_wr,
    output logic [7:0]  net_byte,
    output logic        tx_active,
    output tx_state_t   o_dbg_state
);

    localparam int SAMPLES = (PACKET_SIZE - 1) / 2;
    localparam int IDX_W   = $clog2(PACKET_SIZE);
    localparam int CNT_W   = $clog2(SAMPLES + 1);
    localparam logic [IDX_W-1:0] LAST_BODY = IDX_W'(PACKET_SIZE - 2);

    tx_state_t        r_state, w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_ctrl_reg;
    logic             r_ctrl_pending;
    logic             r_pkt_ctrl;

    logic [CNT_W-1:0] w_count;
    logic             w_buf_full;
    logic [7:0]       w_buf_byte;
    logic             w_active, w_busy, w_net_wr, w_pkt_done;
    logic             w_accept, w_acc_ctrl, w_acc_audio;
    logic             w_ctrl_ready, w_audio_ready;
    logic [7:0]       w_byte, w_trailer;

    // Handshake: a word is taken on any edge where session_send is non-zero and
    // session_busy is low; busy depends on registered state only, so the session can
    // sample it at any point in the cycle. Words offered while busy are discarded.
    assign w_active    = (r_state != S_IDLE);
    assign w_busy      = w_active | r_ctrl_pending | w_buf_full;
    assign w_accept    = (session_send != KIND_NONE) && !w_busy;
    assign w_acc_ctrl  = w_accept && (session_send == KIND_CONTROL);
    assign w_acc_audio = w_accept && (session_send == KIND_AUDIO);

    // Include this cycle's word so the header follows acceptance by one cycle.
    assign w_ctrl_ready  = r_ctrl_pending | w_acc_ctrl;
    assign w_audio_ready = w_buf_full | (w_acc_audio && w_count == CNT_W'(SAMPLES - 1));

    assign w_net_wr   = w_active & ~net_full;
    assign w_pkt_done = (r_state == S_TRAIL) & w_net_wr;

    tx_sample_buffer #(
        .SAMPLES (SAMPLES),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_pkt_done & ~r_pkt_ctrl),
        .i_wr      (w_acc_audio),
        .i_data    (session_data),
        .i_rd_idx  (r_idx),
        .o_count   (w_count),
        .o_full    (w_buf_full),
        .o_rd_byte (w_buf_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_ctrl_ready || w_audio_ready) w_next_state = S_HDR;
            S_HDR:   if (w_net_wr) w_next_state = S_BODY;
            S_BODY:  if (w_net_wr && r_idx == LAST_BODY) w_next_state = S_TRAIL;
            S_TRAIL: if (w_net_wr) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx          <= '0;
            r_ctrl_reg     <= 16'h0000;
            r_ctrl_pending <= 1'b0;
            r_pkt_ctrl     <= 1'b0;
        end else begin
            if (w_net_wr) begin
                r_idx <= (r_state == S_TRAIL) ? '0 : r_idx + IDX_W'(1);
            end
            if (w_acc_ctrl) begin
                r_ctrl_reg     <= session_data;
                r_ctrl_pending <= 1'b1;
            end else if (w_pkt_done && r_pkt_ctrl) begin
                r_ctrl_pending <= 1'b0;
            end
            // Control wins over a full audio buffer; the buffer waits for the next slot.
            if (r_state == S_IDLE && w_next_state == S_HDR) begin
                r_pkt_ctrl <= w_ctrl_ready;
            end
        end
    end

`ifdef TX_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= 8'h00;
        end else if (w_net_wr) begin
            r_csum <= (r_state == S_TRAIL) ? 8'h00 : (r_csum ^ w_byte);
        end
    end

    assign w_trailer = r_csum;
`else
    assign w_trailer = 8'h00;
`endif

    // Depends only on registered state, so the byte holds steady through a stall.
    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            S_HDR:   w_byte = r_pkt_ctrl ? HDR_CONTROL : HDR_AUDIO;
            S_BODY: begin
                if (!r_pkt_ctrl)                 w_byte = w_buf_byte;
                else if (r_idx == IDX_W'(1))     w_byte = r_ctrl_reg[15:8];
                else if (r_idx == IDX_W'(2))     w_byte = r_ctrl_reg[7:0];
            end
            S_TRAIL: w_byte = w_trailer;
            default: w_byte = 8'h00;
        endcase
    end

    assign session_busy = w_busy;
    assign net_wr       = w_net_wr;
    assign net_byte     = w_byte;
    assign tx_active    = w_active;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_transport_send.sv
// Bench for transport_send: directed scenarios then random traffic, checked against a
// packet-level reference model feeding an expected-byte queue.
module tb_transport_send;
  import transport_pkg::*;

  localparam int PS = 16;
  localparam int NS = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  session_send = 2'b00;
  logic [15:0] session_data = 16'h0000;
  logic        session_busy;
  logic        net_full = 1'b0;
  logic        net_wr;
  logic [7:0]  net_byte;
  logic        tx_active;
  tx_state_t   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q[$];

  // reference model state
  bit          m_valid = 0;
  bit          m_just_reset = 0;
  bit          m_active = 0;
  bit          m_pkt_ctrl = 0;
  int          m_left = 0;
  bit          m_ctrl_pend = 0;
  logic [15:0] m_ctrl = 16'h0;
  logic [15:0] m_samples[$];

  transport_send #(.PACKET_SIZE(PS)) dut (
    .clk          (clk),
    .reset        (reset),
    .session_send (session_send),
    .session_data (session_data),
    .session_busy (session_busy),
    .net_full     (net_full),
    .net_wr       (net_wr),
    .net_byte     (net_byte),
    .tx_active    (tx_active),
    .o_dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build a whole packet from the format rules and queue every byte of it.
  task automatic queue_packet(input bit is_ctrl);
    logic [7:0] pkt[PS];
    logic [7:0] x;
    for (int i = 0; i < PS; i++) pkt[i] = 8'h00;
    if (is_ctrl) begin
      pkt[0] = 8'h40;
      pkt[1] = m_ctrl[15:8];
      pkt[2] = m_ctrl[7:0];
    end else begin
      pkt[0] = 8'h80;
      for (int s = 0; s < NS; s++) begin
        pkt[1 + 2*s] = m_samples[s][15:8];
        pkt[2 + 2*s] = m_samples[s][7:0];
      end
    end
    x = 8'h00;
`ifdef TX_CHECKSUM_EN
    for (int i = 0; i < PS - 1; i++) x = x ^ pkt[i];
`endif
    pkt[PS-1] = x;
    for (int i = 0; i < PS; i++) exp_q.push_back(pkt[i]);
    m_active   = 1;
    m_pkt_ctrl = is_ctrl;
    m_left     = PS;
  endtask

  // Monitor + model: checks outputs each cycle, then advances the model to the next edge.
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_wr;
    exp_busy = m_active || m_ctrl_pend || (m_samples.size() == NS);
    exp_wr   = m_active && !net_full;
    if (m_valid) begin
      chk("session_busy", 32'(session_busy), 32'(exp_busy));
      chk("tx_active", 32'(tx_active), 32'(m_active));
      chk("net_wr", 32'(net_wr), 32'(exp_wr));
      chk("fsm_busy_state", 32'(dbg_state != S_IDLE), 32'(m_active));
      if (m_just_reset) chk("net_byte_after_reset", 32'(net_byte), 32'h0);
      if (m_active) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL net_byte: got %0h, expected nothing (queue empty) at %0t", net_byte, $time);
        end else begin
          chk("net_byte", 32'(net_byte), 32'(exp_q[0]));
          if (net_wr) void'(exp_q.pop_front());
        end
      end
    end
    if (reset) begin
      m_valid      = 1;
      m_just_reset = 1;
      m_active     = 0;
      m_ctrl_pend  = 0;
      m_left       = 0;
      m_samples.delete();
      exp_q.delete();
    end else if (m_valid) begin
      m_just_reset = 0;
      if (exp_wr) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 0;
          if (m_pkt_ctrl) m_ctrl_pend = 0;
          else m_samples.delete();
        end
      end else if (!m_active) begin
        if (!exp_busy && session_send == 2'b01) begin
          m_ctrl_pend = 1;
          m_ctrl      = session_data;
        end else if (!exp_busy && session_send == 2'b10) begin
          m_samples.push_back(session_data);
        end
        if (m_ctrl_pend) queue_packet(1'b1);
        else if (m_samples.size() == NS) queue_packet(1'b0);
      end
    end
  end

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic drive_raw(input logic [1:0] kind, input logic [15:0] data);
    session_send = kind;
    session_data = data;
    @(posedge clk); #1;
    session_send = 2'b00;
  endtask

  task automatic send_word(input logic [1:0] kind, input logic [15:0] data);
    int t;
    t = 0;
    while (session_busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (session_busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: busy still %0b after %0d cycles", session_busy, t);
    end
    drive_raw(kind, data);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((tx_active || session_busy) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (tx_active) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: tx_active still %0b after %0d cycles", tx_active, t);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: single control word, no back-pressure
    send_word(2'b01, 16'hBEEF);
    wait_idle();

    // 2: seven ascending audio samples
    for (int i = 0; i < NS; i++) send_word(2'b10, 16'(16'h0102 + i * 16'h0202));
    wait_idle();

    // 3: four-cycle stall at byte 5
    send_word(2'b01, 16'hA55A);
    repeat (5) @(posedge clk);
    #1 net_full = 1'b1;
    repeat (4) @(posedge clk);
    #1 net_full = 1'b0;
    wait_idle();

    // 6: words offered while busy, and the illegal kind while idle
    send_word(2'b01, 16'h7777);
    drive_raw(2'b10, 16'hDEAD);
    drive_raw(2'b01, 16'hCAFE);
    wait_idle();
    drive_raw(2'b11, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;

    // 4: control overtakes a partial audio buffer
    for (int i = 0; i < NS - 1; i++) send_word(2'b10, 16'(16'h1100 + i));
    send_word(2'b01, 16'h1234);
    send_word(2'b10, 16'h1106);
    wait_idle();

    // 5: reset in the middle of an audio packet
    for (int i = 0; i < NS; i++) send_word(2'b10, 16'($urandom));
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send_word(2'b01, 16'h5A5A);
    wait_idle();

    // random traffic with random back-pressure
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0:       session_send = 2'b01;
        1:       session_send = 2'b11;
        2, 3:    session_send = 2'b00;
        default: session_send = 2'b10;
      endcase
      session_data = 16'($urandom);
      net_full = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    session_send = 2'b00;
    net_full = 1'b0;
    begin
      int t;
      t = 0;
      while (tx_active && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
